// File: rtl/pmt_pkg.sv
// Shared constants and record types for the PMT table and its lookup path.
// The sizes here must agree with sram_pmt.
package pmt_pkg;

    localparam int PMT_DATA_WIDTH = 32;
    localparam int PMT_ADDR_WIDTH = 5;
    localparam int PMT_DEPTH      = 32;
    localparam int PMT_RD_LAT     = 2;
    localparam int PMT_TAG_WIDTH  = 8;
    localparam int PMT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [PMT_DATA_WIDTH-1:0] data;
        logic                      hit;
        logic [PMT_TAG_WIDTH-1:0]  tag;
    } pmt_resp_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pmt_resp_fifo.sv
// Synchronous response FIFO for the PMT lookup path.
// The head and count come straight from registers; the head reads as zero while empty.
module pmt_resp_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH-1)) ? '0 : ptr + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme must never push into a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop))
        else $error("pmt_resp_fifo overflow");

endmodule

// File: rtl/pmt_lookup_ctrl.sv
// Read-side initiator for the PMT table: issues SRAM reads, realigns the fixed-latency
// return with its request, buffers results and delivers them in order under backpressure.
module pmt_lookup_ctrl
    import pmt_pkg::*;
#(
    parameter int DATA_WIDTH = PMT_DATA_WIDTH,
    parameter int ADDR_WIDTH = PMT_ADDR_WIDTH,
    parameter int DEPTH      = PMT_DEPTH,
    parameter int TAG_WIDTH  = PMT_TAG_WIDTH,
    parameter int RD_LAT     = PMT_RD_LAT,
    parameter int FIFO_DEPTH = PMT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  sram_rd_en,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic [DATA_WIDTH-1:0] sram_rd_data,
    input  logic                  sram_rd_valid,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_hit,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic [31:0]           stat_lookups,
    output logic [31:0]           stat_hits
);

    localparam int RESP_W = DATA_WIDTH + 1 + TAG_WIDTH;
    localparam int FCW    = $clog2(FIFO_DEPTH+1);
    localparam int OW     = $clog2(FIFO_DEPTH+RD_LAT+1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  hit;
        logic [TAG_WIDTH-1:0]  tag;
    } resp_t;

    typedef struct packed {
        logic                 issued;
        logic                 force_miss;
        logic [TAG_WIDTH-1:0] tag;
    } pipe_t;

    pipe_t           pipe [RD_LAT];
    logic            running;
    logic            in_range;
    logic            accept;
    logic            pop;
    logic [OW-1:0]   inflight;
    logic [FCW-1:0]  fifo_count;
    logic            fifo_empty;
    logic            ret_hit;
    resp_t           push_rec;
    resp_t           head_rec;

    generate
        if (DEPTH >= (1 << ADDR_WIDTH)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = (int'(req_addr) < DEPTH);
        end
    endgenerate

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OW'(pipe[i].issued);
        end
    end

    // Credits count both buffered and still-in-flight responses, so a push can never overflow.
    assign req_ready    = running & ((OW'(fifo_count) + inflight) < OW'(FIFO_DEPTH));
    assign accept       = req_valid & req_ready;
    assign sram_rd_en   = accept & in_range;
    assign sram_rd_addr = sram_rd_en ? req_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    // Out-of-range requests still occupy a slot so responses stay in request order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{issued: accept, force_miss: ~in_range, tag: req_tag};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign ret_hit       = sram_rd_valid & ~pipe[RD_LAT-1].force_miss;
    assign push_rec.data = ret_hit ? sram_rd_data : '0;
    assign push_rec.hit  = ret_hit;
    assign push_rec.tag  = pipe[RD_LAT-1].tag;

    pmt_resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe[RD_LAT-1].issued),
        .push_data (push_rec),
        .pop       (pop),
        .head      (head_rec),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign resp_valid = ~fifo_empty;
    assign resp_data  = head_rec.data;
    assign resp_hit   = head_rec.hit;
    assign resp_tag   = head_rec.tag;
    assign pop        = resp_valid & resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
        end else begin
            if (accept) begin
                stat_lookups <= sat_inc(stat_lookups);
            end
            if (pop && head_rec.hit) begin
                stat_hits <= sat_inc(stat_hits);
            end
        end
    end

endmodule

// File: tb/tb_pmt_lookup_ctrl.sv
// Scoreboard bench for pmt_lookup_ctrl built with a 24-entry range so out-of-range
// indices can be exercised; a small SRAM model supplies the fixed-latency read data.
module tb_pmt_lookup_ctrl;
    import pmt_pkg::*;

    localparam int TB_DEPTH = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic [7:0]  req_tag;
    logic        sram_rd_en;
    logic [4:0]  sram_rd_addr;
    logic [31:0] sram_rd_data;
    logic        sram_rd_valid;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_hit;
    logic [7:0]  resp_tag;
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;

    pmt_lookup_ctrl #(.DEPTH(TB_DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_tag       (req_tag),
        .sram_rd_en    (sram_rd_en),
        .sram_rd_addr  (sram_rd_addr),
        .sram_rd_data  (sram_rd_data),
        .sram_rd_valid (sram_rd_valid),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_hit      (resp_hit),
        .resp_tag      (resp_tag),
        .stat_lookups  (stat_lookups),
        .stat_hits     (stat_hits)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cycleCount = 0;
    int          readyMode = 1;
    int          lookupsExp = 0;
    int          hitsExp = 0;
    int          stallCount = 0;
    int          acceptCycle = 0;
    pmt_resp_t   expQ[$];
    int          popCycles[$];
    logic [31:0] tableMem [32];
    logic        programmed [32];

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // resp_ready: 0 = stalled, 1 = always ready, 2 = random backpressure
    always @(negedge clk) begin
        case (readyMode)
            0:       resp_ready = 1'b0;
            1:       resp_ready = 1'b1;
            default: resp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // SRAM model: a read issued in cycle N returns in cycle N+2; junk data when not valid.
    logic [31:0] s0Data = '0, s1Data = '0;
    logic        s0Valid = 1'b0, s1Valid = 1'b0;
    always @(posedge clk) begin
        s1Data  <= s0Data;
        s1Valid <= s0Valid;
        if (sram_rd_en) begin
            s0Valid <= programmed[sram_rd_addr];
            s0Data  <= programmed[sram_rd_addr] ? tableMem[sram_rd_addr]
                                                : (32'hBAD0_0000 | 32'(sram_rd_addr));
        end else begin
            s0Valid <= 1'b0;
            s0Data  <= $urandom;
        end
    end
    assign sram_rd_data  = s1Data;
    assign sram_rd_valid = s1Valid;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic pmt_resp_t refLookup(input logic [4:0] addr, input logic [7:0] tag);
        pmt_resp_t r;
        r.tag  = tag;
        r.hit  = (int'(addr) < TB_DEPTH) && programmed[addr];
        r.data = r.hit ? tableMem[addr] : 32'd0;
        return r;
    endfunction

    // Monitor: compares the presented head with the oldest outstanding expectation,
    // including every stalled cycle, and retires it on a handshake.
    always begin
        pmt_resp_t head;
        @(negedge clk);
        #2;
        if (resp_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_resp", 64'd1, 64'd0);
            end else begin
                head = expQ[0];
                checkOutput("resp_data", 64'(resp_data), 64'(head.data));
                checkOutput("resp_hit", 64'(resp_hit), 64'(head.hit));
                checkOutput("resp_tag", 64'(resp_tag), 64'(head.tag));
                if (resp_ready) begin
                    void'(expQ.pop_front());
                    if (head.hit) hitsExp++;
                    popCycles.push_back(cycleCount);
                end
            end
        end
    end

    // Issues one request starting at a negedge and returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [4:0] addr, input logic [7:0] tag);
        int waited = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_tag   = tag;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        stallCount += waited;
        if (!req_ready) begin
            checkOutput("req_ready_timeout", 64'd0, 64'd1);
        end else begin
            #1;
            checkOutput("sram_rd_en", 64'(sram_rd_en), (int'(addr) < TB_DEPTH) ? 64'd1 : 64'd0);
            if (int'(addr) < TB_DEPTH) checkOutput("sram_rd_addr", 64'(sram_rd_addr), 64'(addr));
            expQ.push_back(refLookup(addr, tag));
            lookupsExp++;
            acceptCycle = cycleCount;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkStats();
        checkOutput("stat_lookups", 64'(stat_lookups), 64'(lookupsExp));
        checkOutput("stat_hits", 64'(stat_hits), 64'(hitsExp));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int accepted;
        int nextIdx;
        req_valid = 1'b0;
        req_addr  = '0;
        req_tag   = '0;
        for (int i = 0; i < 32; i++) begin
            tableMem[i]   = 32'd0;
            programmed[i] = 1'b0;
        end
        tableMem[5]  = 32'hDEAD_BEEF; programmed[5]  = 1'b1;
        tableMem[0]  = 32'h0000_1000; programmed[0]  = 1'b1;
        tableMem[1]  = 32'h1111_0001; programmed[1]  = 1'b1;
        tableMem[2]  = 32'h2222_0002; programmed[2]  = 1'b1;
        tableMem[6]  = 32'h6666_0006; programmed[6]  = 1'b1;
        tableMem[30] = 32'h3030_3030; programmed[30] = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset_stat_lookups", 64'(stat_lookups), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_req_ready", 64'(req_ready), 64'd1);
        checkOutput("post_reset_resp_valid", 64'(resp_valid), 64'd0);

        $display("[TB] single hit");
        applyStimulus(5'd5, 8'h11);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("single_latency", 64'(cycleCount - acceptCycle), 64'd3);
        waitDrain();
        checkStats();

        $display("[TB] miss");
        applyStimulus(5'd9, 8'h22);
        waitDrain();
        checkStats();

        $display("[TB] back-to-back");
        stallCount = 0;
        popCycles.delete();
        for (int i = 0; i < 8; i++) applyStimulus(5'(i), 8'(i));
        waitDrain();
        checkOutput("b2b_stalls", 64'(stallCount), 64'd0);
        checkOutput("b2b_pops", 64'(popCycles.size()), 64'd8);
        if (popCycles.size() == 8) checkOutput("b2b_span", 64'(popCycles[7] - popCycles[0]), 64'd7);
        checkStats();

        $display("[TB] backpressure");
        readyMode = 0;
        repeat (2) @(negedge clk);
        accepted = 0;
        nextIdx = 10;
        req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_addr = 5'(nextIdx);
            req_tag  = 8'(8'h40 + nextIdx);
            if (req_ready) begin
                expQ.push_back(refLookup(req_addr, req_tag));
                lookupsExp++;
                accepted++;
                nextIdx++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("bp_accepted", 64'(accepted), 64'(PMT_FIFO_DEPTH));
        checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
        readyMode = 1;
        waitDrain();
        checkStats();

        $display("[TB] out-of-range");
        applyStimulus(5'd1, 8'hA1);
        applyStimulus(5'd30, 8'hA2);
        applyStimulus(5'd2, 8'hA3);
        waitDrain();
        checkStats();

        $display("[TB] random traffic");
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(0, 31);
            tableMem[n]   = $urandom;
            programmed[n] = 1'b1;
        end
        readyMode = 2;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(5'($urandom_range(0, 31)), 8'($urandom));
        end
        readyMode = 1;
        waitDrain();
        checkStats();

        $display("[TB] reset mid-stream");
        readyMode = 0;
        repeat (2) @(negedge clk);
        applyStimulus(5'd5, 8'hB0);
        applyStimulus(5'd1, 8'hB1);
        applyStimulus(5'd2, 8'hB2);
        applyStimulus(5'd6, 8'hB3);
        rst_n = 1'b0;
        #1;
        expQ.delete();
        lookupsExp = 0;
        hitsExp = 0;
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_resp_data", 64'(resp_data), 64'd0);
        checkOutput("rst_resp_tag", 64'(resp_tag), 64'd0);
        checkOutput("rst_sram_rd_en", 64'(sram_rd_en), 64'd0);
        checkStats();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        readyMode = 1;
        repeat (8) @(negedge clk);
        applyStimulus(5'd5, 8'h55);
        waitDrain();
        checkStats();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
